mem_arbiter: RTL and testbench

//  Shares the single-port RAM between the instruction-fetch path (icache side) and the

---
 rtl/aww_types_pkg.sv | 13 +
 rtl/cpu_types_pkg.sv | 13 +
 rtl/mem_arb_perf.sv | 31 +++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aww_types_pkg.sv
// rtl/aww_types_pkg.sv - memory arbiter FSM state and starvation counter width
package aww_types_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IGRANT = 2'd1,
    ARB_DGRANT = 2'd2
  } arb_state_t;

  // Wide enough for any STARVE_LIMIT in 1..15
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared core types: machine word and RAM handshake state
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arb_perf.sv
// rtl/mem_arb_perf.sv - wrapping counters of completed I/D transactions and stalled cycles
module mem_arb_perf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_done_i,
  input  logic        d_done_i,
  input  logic        stall_i,
  output logic [31:0] igrant_cnt_o,
  output logic [31:0] dgrant_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] igrant_q, dgrant_q, stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      igrant_q <= '0;
      dgrant_q <= '0;
      stall_q  <= '0;
    end else begin
      if (i_done_i) igrant_q <= igrant_q + 32'd1;
      if (d_done_i) dgrant_q <= dgrant_q + 32'd1;
      if (stall_i)  stall_q  <= stall_q + 32'd1;
    end
  end

  assign igrant_cnt_o = igrant_q;
  assign dgrant_cnt_o = dgrant_q;
  assign stall_cnt_o  = stall_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter, data priority with bounded fetch starvation
// MEM_ARB_PERF_EN adds igrant_cnt/dgrant_cnt/stall_cnt performance counter ports.
module mem_arbiter
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] igrant_cnt,
  output logic [31:0] dgrant_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                dreq, i_done, d_done, i_wins;

  always_comb begin
    dreq   = dREN | dWEN;
    i_wins = iREN && (!dreq || (starve_q == LIMIT));
    i_done = (state_q == ARB_IGRANT) && iREN && (ramstate == ACCESS);
    d_done = (state_q == ARB_DGRANT) && dreq && (ramstate == ACCESS);
  end

  // A dropped request or an ERROR reply abandons the grant and re-arbitrates
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_wins)    state_d = ARB_IGRANT;
        else if (dreq) state_d = ARB_DGRANT;
      end
      ARB_IGRANT: begin
        if (!iREN || ramstate == ACCESS || ramstate == ERROR) state_d = ARB_IDLE;
        if (i_done) starve_d = '0;
      end
      ARB_DGRANT: begin
        if (!dreq || ramstate == ACCESS || ramstate == ERROR) state_d = ARB_IDLE;
        if (d_done) begin
          if (!iREN)                 starve_d = '0;
          else if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    iwait    = !i_done;
    dwait    = !d_done;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      ARB_IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      ARB_DGRANT: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

  a_no_dual_data_req : assert property (@(posedge CLK) disable iff (RST) !(dREN && dWEN));

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .clk_i        (CLK),
    .rst_i        (RST),
    .i_done_i     (i_done),
    .d_done_i     (d_done),
    .stall_i      ((iREN && iwait) || (dreq && dwait)),
    .igrant_cnt_o (igrant_cnt),
    .dgrant_cnt_o (dgrant_cnt),
    .stall_cnt_o  (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed plus randomized checks of mem_arbiter against a grant-owner model
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;

  logic      CLK = 1'b0;
  logic      RST = 1'b1;
  logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t ramstate = FREE;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] igrant_cnt, dgrant_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
`ifdef MEM_ARB_PERF_EN
    ,
    .igrant_cnt (igrant_cnt),
    .dgrant_cnt (dgrant_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the RAM (0 none, 1 I, 2 D) and how many D services happened while I waited
  int          own = 0;
  int          streak = 0;
  bit          m_idone = 0, m_ddone = 0;
  int unsigned m_ic = 0, m_dc = 0, m_st = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      own = 0; streak = 0; m_idone = 0; m_ddone = 0;
      m_ic = 0; m_dc = 0; m_st = 0;
    end else begin : mdl
      bit dq, srv_i, srv_d;
      dq    = dREN || dWEN;
      srv_i = (own == 1) && iREN && (ramstate == ACCESS);
      srv_d = (own == 2) && dq && (ramstate == ACCESS);
      if ((iREN && !srv_i) || (dq && !srv_d)) m_st++;
      if (own == 0) begin
        if (iREN && (!dq || streak == LIMIT)) own = 1;
        else if (dq)                          own = 2;
      end else if (own == 1) begin
        if (srv_i) begin own = 0; streak = 0; m_ic++; end
        else if (!iREN || ramstate == ERROR) own = 0;
      end else begin
        if (srv_d) begin
          own = 0;
          streak = iREN ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
          m_dc++;
        end else if (!dq || ramstate == ERROR) own = 0;
      end
      m_idone = srv_i;
      m_ddone = srv_d;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin : cmp
      bit    dq, e_iw, e_dw, e_rr, e_rw;
      word_t e_ad, e_st;
      dq   = dREN || dWEN;
      e_iw = !((own == 1) && iREN && (ramstate == ACCESS));
      e_dw = !((own == 2) && dq && (ramstate == ACCESS));
      e_rr = (own == 1) || ((own == 2) && !dWEN);
      e_rw = (own == 2) && dWEN;
      e_ad = (own == 1) ? iaddr : ((own == 2) ? daddr : 32'h0);
      e_st = e_rw ? dstore : 32'h0;
      chk("cyc_iwait", 32'(iwait), 32'(e_iw));
      chk("cyc_dwait", 32'(dwait), 32'(e_dw));
      chk("cyc_ramREN", 32'(ramREN), 32'(e_rr));
      chk("cyc_ramWEN", 32'(ramWEN), 32'(e_rw));
      chk("cyc_ramaddr", ramaddr, e_ad);
      chk("cyc_ramstore", ramstore, e_st);
      if (!e_iw) chk("cyc_iload", iload, ramload);
      if (!e_dw && dREN) chk("cyc_dload", dload, ramload);
`ifdef MEM_ARB_PERF_EN
      chk("cyc_igrant_cnt", igrant_cnt, m_ic);
      chk("cyc_dgrant_cnt", dgrant_cnt, m_dc);
      chk("cyc_stall_cnt", stall_cnt, m_st);
`endif
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  // Called at +1 with requests applied; returns at +3 of the cycle I is served
  task automatic count_d_before_i(output int nd);
    bit done;
    done = 0;
    nd = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      #2;
      if (dwait === 1'b0) nd++;
      if (iwait === 1'b0) done = 1;
      else step();
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL starve_timeout: iwait stayed high for 80 cycles, want low");
    end
  endtask

  initial begin
    int nd;
    bit i_act, d_act;
    i_act = 0;
    d_act = 0;

    #3;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    step();
    step();
    RST = 1'b0;

    // 1: single fetch, immediate ACCESS
    iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #2;
    chk("t1_c0_ramREN", 32'(ramREN), 32'd0);
    chk("t1_c0_iwait", 32'(iwait), 32'd1);
    step(); #2;
    chk("t1_c1_ramREN", 32'(ramREN), 32'd1);
    chk("t1_c1_ramaddr", ramaddr, 32'h40);
    chk("t1_c1_iwait", 32'(iwait), 32'd0);
    chk("t1_c1_iload", iload, 32'hDEADBEEF);
    step(); iREN = 1'b0; #2;
    chk("t1_c2_ramREN", 32'(ramREN), 32'd0);
    chk("t1_c2_iwait", 32'(iwait), 32'd1);

    // 2: simultaneous I and D, D first, one IDLE between
    step();
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; ramload = 32'hA5A5_0001;
    #2;
    chk("t2_c0_dwait", 32'(dwait), 32'd1);
    step(); #2;
    chk("t2_c1_ramaddr", ramaddr, 32'h100);
    chk("t2_c1_dwait", 32'(dwait), 32'd0);
    chk("t2_c1_iwait", 32'(iwait), 32'd1);
    chk("t2_c1_dload", dload, 32'hA5A5_0001);
    step(); dREN = 1'b0; #2;
    chk("t2_c2_ramREN", 32'(ramREN), 32'd0);
    chk("t2_c2_iwait", 32'(iwait), 32'd1);
    step(); #2;
    chk("t2_c3_ramaddr", ramaddr, 32'h44);
    chk("t2_c3_iwait", 32'(iwait), 32'd0);
    step(); clear_req();
    step();

    // 3: starvation bound
    iREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'h0BAD_F00D;
    count_d_before_i(nd);
    chk("t3_d_before_i", nd, 32'd4);
    step(); clear_req();
    step();
    iREN = 1'b1; dREN = 1'b1;
    step(); #2;
    chk("t3_after_i_d_wins", 32'(dwait), 32'd0);
    chk("t3_after_i_iwait", 32'(iwait), 32'd1);
    step(); clear_req();
    step();

    // 4: write held across BUSY
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234_5678; ramstate = BUSY;
    #2;
    chk("t4_c0_ramWEN", 32'(ramWEN), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) ramstate = ACCESS;
      #2;
      chk("t4_ramWEN", 32'(ramWEN), 32'd1);
      chk("t4_ramaddr", ramaddr, 32'h200);
      chk("t4_ramstore", ramstore, 32'h1234_5678);
      chk("t4_dwait", 32'(dwait), (k == 4) ? 32'd0 : 32'd1);
    end
    step(); clear_req();
    step();

    // 5: ERROR retry of a fetch
    iREN = 1'b1; iaddr = 32'h80; ramstate = ERROR;
    step(); #2;
    chk("t5_err_ramREN", 32'(ramREN), 32'd1);
    chk("t5_err_iwait", 32'(iwait), 32'd1);
    step(); #2;
    chk("t5_idle_ramREN", 32'(ramREN), 32'd0);
    step(); ramstate = ACCESS; #2;
    chk("t5_retry_ramaddr", ramaddr, 32'h80);
    chk("t5_retry_iwait", 32'(iwait), 32'd0);
    step(); clear_req();
    step();

    // 6: async reset mid-write clears outputs and starvation history
    iREN = 1'b1; dWEN = 1'b1; daddr = 32'h400; ramstate = ACCESS;
    step(); #2;
    chk("t6_first_d_done", 32'(dwait), 32'd0);
    step(); ramstate = BUSY;
    step(); #2;
    chk("t6_dgrant_ramWEN", 32'(ramWEN), 32'd1);
    RST = 1'b1;
    #1;
    chk("t6_rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("t6_rst_ramREN", 32'(ramREN), 32'd0);
    chk("t6_rst_iwait", 32'(iwait), 32'd1);
    chk("t6_rst_dwait", 32'(dwait), 32'd1);
`ifdef MEM_ARB_PERF_EN
    chk("t6_rst_igrant_cnt", igrant_cnt, 32'd0);
    chk("t6_rst_dgrant_cnt", dgrant_cnt, 32'd0);
    chk("t6_rst_stall_cnt", stall_cnt, 32'd0);
`endif
    step();
    RST = 1'b0; ramstate = ACCESS;
    count_d_before_i(nd);
    chk("t6_d_before_i_after_rst", nd, 32'd4);
    step(); clear_req();
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      if (i_act) begin
        if (m_idone || $urandom_range(0, 49) == 0) begin i_act = 0; iREN = 1'b0; end
      end else if ($urandom_range(0, 2) == 0) begin
        i_act = 1; iREN = 1'b1; iaddr = $urandom;
      end
      if (d_act) begin
        if (m_ddone || $urandom_range(0, 49) == 0) begin d_act = 0; dREN = 1'b0; dWEN = 1'b0; end
      end else if ($urandom_range(0, 2) == 0) begin
        d_act = 1; daddr = $urandom; dstore = $urandom;
        if ($urandom_range(0, 1) == 1) begin dWEN = 1'b1; dREN = 1'b0; end
        else begin dREN = 1'b1; dWEN = 1'b0; end
      end
      case ($urandom_range(0, 9))
        6, 7:    ramstate = BUSY;
        8:       ramstate = FREE;
        9:       ramstate = ERROR;
        default: ramstate = ACCESS;
      endcase
      ramload = $urandom;
    end
    step();
    clear_req();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
